// File: rtl/rr_decode_arbiter_pkg.sv
// Shared constants, state encoding and index helpers for the round-robin decode arbiter.
package arb_pkg;

    localparam int unsigned N_REQ = 16;
    localparam int unsigned IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        REL   = 2'd2
    } arb_state_e;

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
        return i + IDX_W'(1);
    endfunction

endpackage

// File: rtl/rr_decode_arbiter_if.sv
// Requester-side handshake and grant bus of the round-robin decode arbiter.
interface rr_decode_arbiter_if;
    import arb_pkg::*;

    logic             en;
    logic [N_REQ-1:0] req;
    logic             done;
    logic             grant_vld;
    logic [IDX_W-1:0] grant_idx;
    logic [N_REQ-1:0] grant_onehot;
    logic             timeout;
    logic             busy;

    modport master (
        output en, req, done,
        input  grant_vld, grant_idx, grant_onehot, timeout, busy
    );

    modport slave (
        input  en, req, done,
        output grant_vld, grant_idx, grant_onehot, timeout, busy
    );

endinterface

// File: rtl/rr_decode_arbiter_onehot_dec4x16.sv
// Enable-gated 4-to-16 one-hot decoder; all outputs low when disabled.
module onehot_dec4x16
    import arb_pkg::*;
(
    input  logic             en,
    input  logic [IDX_W-1:0] idx,
    output logic [N_REQ-1:0] y
);

    always_comb begin
        y = '0;
        if (en) begin
            y[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter for 16 requesters with hold timeout, a mandatory release
// cycle, and a registered one-hot grant decoded from the next grant index.
module rr_decode_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst,
    rr_decode_arbiter_if.slave bus
);

    localparam logic [7:0] HOLD_MAX  = 8'(MAX_HOLD);
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    arb_state_e       state, state_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [7:0]       hold_cnt, hold_cnt_nxt;
    logic             grant_vld_q, grant_vld_nxt;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_nxt;
    logic [N_REQ-1:0] grant_onehot_q, onehot_nxt;
    logic             timeout_q, timeout_nxt;

    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic             hold_hit;
    logic             release_now;

    // First requester at or after p, wrapping 15 -> 0; MSB of the result flags a hit.
    function automatic logic [IDX_W:0] rr_scan(input logic [N_REQ-1:0] r,
                                               input logic [IDX_W-1:0] p);
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] cand;
        res = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = p + IDX_W'(k);
            if (!res[IDX_W] && r[cand]) begin
                res = {1'b1, cand};
            end
        end
        return res;
    endfunction

    always_comb begin
        {win_found, win_idx} = rr_scan(bus.req, ptr);
    end

    assign hold_hit    = (hold_cnt == HOLD_LAST);
    assign release_now = bus.done || !bus.req[grant_idx_q] || !bus.en || hold_hit;

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        hold_cnt_nxt  = hold_cnt;
        grant_vld_nxt = grant_vld_q;
        grant_idx_nxt = grant_idx_q;
        timeout_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.en && win_found) begin
                    state_nxt     = GRANT;
                    grant_idx_nxt = win_idx;
                    grant_vld_nxt = 1'b1;
                    hold_cnt_nxt  = '0;
                end
            end
            GRANT: begin
                hold_cnt_nxt = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 8'd1;
                if (release_now) begin
                    state_nxt     = REL;
                    grant_vld_nxt = 1'b0;
                    ptr_nxt       = idx_inc(grant_idx_q);
                    // Only a pure hold expiry counts as a timeout.
                    timeout_nxt   = hold_hit && !bus.done && bus.req[grant_idx_q] && bus.en;
                end
            end
            REL: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt     = IDLE;
                grant_vld_nxt = 1'b0;
            end
        endcase
    end

    onehot_dec4x16 u_dec (
        .en  (grant_vld_nxt),
        .idx (grant_idx_nxt),
        .y   (onehot_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            ptr            <= '0;
            hold_cnt       <= '0;
            grant_vld_q    <= 1'b0;
            grant_idx_q    <= '0;
            grant_onehot_q <= '0;
            timeout_q      <= 1'b0;
        end else begin
            state          <= state_nxt;
            ptr            <= ptr_nxt;
            hold_cnt       <= hold_cnt_nxt;
            grant_vld_q    <= grant_vld_nxt;
            grant_idx_q    <= grant_idx_nxt;
            grant_onehot_q <= onehot_nxt;
            timeout_q      <= timeout_nxt;
        end
    end

    assign bus.grant_vld    = grant_vld_q;
    assign bus.grant_idx    = grant_idx_q;
    assign bus.grant_onehot = grant_onehot_q;
    assign bus.timeout      = timeout_q;
    assign bus.busy         = (state == GRANT) || (state == REL);

endmodule
